// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit counter branch predictor with redirect and statistics
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_pc            PC being fetched (word aligned)
//   pred_taken          combinational direction guess for fetch_pc
//   pred_target         combinational next-PC guess for fetch_pc
//   ex_valid            a conditional branch resolves this cycle
//   ex_pc               PC of the resolving branch
//   ex_taken            resolved direction
//   ex_target           computed branch target
//   ex_pred_taken       direction that was predicted for this branch
//   ex_pred_target      next PC that was predicted for this branch
//   redirect_valid      registered single-cycle restart request to fetch
//   redirect_pc         registered correct next PC
//   stat_branches       saturating resolved-branch count
//   stat_mispredicts    saturating mispredict count
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // The two low PC bits are always zero for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  // Reads the registered table only, so a same-cycle update is not visible.
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : (fetch_pc + 32'd4);

  // ---------------- update side ----------------
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic [1:0]       e_ctr;
  logic [1:0]       ctr_next;
  logic             mispredict;
  logic [31:0]      correct_pc;

  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[31:IDX_W+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_ctr = ctr_q[e_idx];

  always_comb begin
    ctr_next = e_ctr;
    if (ex_taken) begin
      if (e_ctr != 2'd3) ctr_next = e_ctr + 2'd1;
    end else begin
      if (e_ctr != 2'd0) ctr_next = e_ctr - 2'd1;
    end
  end

  // A taken branch with the right direction still mispredicts when the
  // carried target differs (e.g. the target changed since allocation).
  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_pred_target != ex_target)));

  assign correct_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  // ---------------- table state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else if (ex_valid) begin
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_next;
        if (ex_taken) target_q[e_idx] <= ex_target;
      end else if (ex_taken) begin
        // Allocate as weakly taken, evicting any aliasing occupant.
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= ex_target;
        ctr_q[e_idx]    <= 2'd2;
      end
    end
  end

  // ---------------- redirect and statistics ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= correct_pc;
      if (ex_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot remembers the full PC it was trained by; a lookup hits when
  // the slot holds exactly that PC. Counter kept as a plain integer 0..3.
  bit          m_v   [16];
  logic [31:0] m_pc  [16];
  logic [31:0] m_tg  [16];
  int          m_ctr [16];
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_pc[i] = 0; m_tg[i] = 0; m_ctr[i] = 1;
    end
    m_rv = 0; m_rpc = 0; m_br = 0; m_mp = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = slot(pc);
    t  = m_v[i] && (m_pc[i] == pc) && (m_ctr[i] >= 2);
    tg = t ? m_tg[i] : pc + 32'd4;
  endtask

  task automatic model_edge();
    int i;
    logic mis;
    if (rst) begin
      model_clear();
      return;
    end
    m_rv = 0;
    if (!ex_valid) return;
    mis = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target);
    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mis) begin
      if (m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      m_rv  = 1;
      m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
    end
    i = slot(ex_pc);
    if (m_v[i] && m_pc[i] == ex_pc) begin
      m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (ex_taken) m_tg[i] = ex_target;
    end else if (ex_taken) begin
      m_v[i] = 1; m_pc[i] = ex_pc; m_tg[i] = ex_target; m_ctr[i] = 2;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic pt, input logic [31:0] ptg,
                       input logic [31:0] fpc);
    rst = r; ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg; fetch_pc = fpc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] fpc;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic tk, logic [31:0] tgt, logic pt,
                              logic [31:0] ptg, logic [31:0] fpc, logic e_pt, logic [31:0] e_ptg,
                              logic e_rv, logic [31:0] e_rpc, logic [31:0] e_br, logic [31:0] e_mp);
    vec_t x;
    x.v = v; x.pc = pc; x.tk = tk; x.tgt = tgt; x.pt = pt; x.ptg = ptg; x.fpc = fpc;
    x.e_pt = e_pt; x.e_ptg = e_ptg; x.e_rv = e_rv; x.e_rpc = e_rpc; x.e_br = e_br; x.e_mp = e_mp;
    return x;
  endfunction

  initial begin
    logic        mt;
    logic [31:0] mtg;
    logic [31:0] rp;
    logic        rt;

    // ex fields                                               | pred (pre-edge) | after edge
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h100, 0, 32'h104, 0, 32'h0,   0,  0));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80,  1,  1));
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h100, 1, 32'h80,  0, 32'h80,  1,  1));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  2,  1));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  3,  1));
    vecs.push_back(mk(1, 32'h100,    0, 32'h80, 1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h104, 4,  2));
    vecs.push_back(mk(1, 32'h100,    0, 32'h80, 1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h104, 5,  3));
    vecs.push_back(mk(1, 32'h100,    0, 32'h80, 0, 32'h104, 32'h100, 0, 32'h104, 0, 32'h104, 6,  3));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80,  7,  4));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80,  8,  5));
    vecs.push_back(mk(1, 32'h100,    1, 32'h80, 1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  9,  5));
    vecs.push_back(mk(1, 32'h100,    1, 32'h90, 1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h90,  10, 6));
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h100, 1, 32'h90,  0, 32'h90,  10, 6));
    vecs.push_back(mk(1, 32'h140,    1, 32'h200, 0, 32'h144, 32'h140, 0, 32'h144, 1, 32'h200, 11, 7));
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h100, 0, 32'h104, 0, 32'h200, 11, 7));
    vecs.push_back(mk(1, 32'h180,    0, 32'h500, 0, 32'h184, 32'h140, 1, 32'h200, 0, 32'h200, 12, 7));
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h140, 1, 32'h200, 0, 32'h200, 12, 7));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 13, 8));
    vecs.push_back(mk(0, 0,          0, 0,     0, 0,     32'h40,  0, 32'h44,  0, 32'h0,   13, 8));

    model_clear();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h100);
    tick();
    tick();

    // reset state
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h100);
    #1;
    chk("reset_pred_taken", {31'd0, pred_taken}, 0);
    chk("reset_pred_target", pred_target, 32'h104);
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_stat_branches", stat_branches, 0);
    chk("reset_stat_mispredicts", stat_mispredicts, 0);

    foreach (vecs[k]) begin
      if (k != 0) @(negedge clk);
      drive(0, vecs[k].v, vecs[k].pc, vecs[k].tk, vecs[k].tgt, vecs[k].pt, vecs[k].ptg, vecs[k].fpc);
      #1;
      chk($sformatf("vec%0d_pred_taken", k), {31'd0, pred_taken}, {31'd0, vecs[k].e_pt});
      chk($sformatf("vec%0d_pred_target", k), pred_target, vecs[k].e_ptg);
      tick();
      chk($sformatf("vec%0d_redirect_valid", k), {31'd0, redirect_valid}, {31'd0, vecs[k].e_rv});
      chk($sformatf("vec%0d_redirect_pc", k), redirect_pc, vecs[k].e_rpc);
      chk($sformatf("vec%0d_stat_branches", k), stat_branches, vecs[k].e_br);
      chk($sformatf("vec%0d_stat_mispredicts", k), stat_mispredicts, vecs[k].e_mp);
    end

    // reset in the same cycle as a mispredicting resolution
    @(negedge clk);
    drive(0, 1, 32'h140, 1, 32'h300, 0, 32'h144, 32'h140);
    tick();
    chk("pre_rst_redirect_valid", {31'd0, redirect_valid}, 1);
    @(negedge clk);
    drive(1, 1, 32'h140, 1, 32'h300, 0, 32'h144, 32'h140);
    tick();
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stat_branches", stat_branches, 0);
    chk("rst_stat_mispredicts", stat_mispredicts, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h140);
    #1;
    chk("rst_table_pred_taken", {31'd0, pred_taken}, 0);
    chk("rst_table_pred_target", pred_target, 32'h144);

    // branch counter saturation
    force dut.stat_branches = 32'hFFFF_FFFE;
    #1;
    release dut.stat_branches;
    m_br = 32'hFFFF_FFFE;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive(0, 1, 32'h200, 0, 32'h0, 0, 32'h204, 32'h200);
      tick();
      chk($sformatf("sat_stat_branches_%0d", n), stat_branches, 32'hFFFF_FFFF);
      chk($sformatf("sat_redirect_valid_%0d", n), {31'd0, redirect_valid}, 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      rp = 32'h100 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      model_pred(rp, mt, mtg);
      if ($urandom_range(0, 1) == 0) begin
        rt  = mt;
      end else begin
        rt  = 1'($urandom_range(0, 1));
        mtg = ($urandom_range(0, 1) == 0) ? mtg : (32'h1000 | ($urandom_range(0, 7) << 2));
      end
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), rp,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? mtg : (32'h1000 | ($urandom_range(0, 7) << 2)),
            rt, mtg,
            32'h100 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      #1;
      model_pred(fetch_pc, mt, mtg);
      chk("rand_pred_taken", {31'd0, pred_taken}, {31'd0, mt});
      chk("rand_pred_target", pred_target, mtg);
      tick();
      chk("rand_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      chk("rand_redirect_pc", redirect_pc, m_rpc);
      chk("rand_stat_branches", stat_branches, m_br);
      chk("rand_stat_mispredicts", stat_mispredicts, m_mp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
